// File: rtl/spi_sd_pkg.sv
// Shared definitions for the SD-card SPI master: register offsets, bytesel codes,
// CTRL bit positions and the bus-side FSM state type.
package spi_sd_pkg;

    localparam logic [3:0] ADDR_DATA   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_CTRL   = 4'h8;

    localparam logic [3:0] BSEL_BYTE = 4'b0001;
    localparam logic [3:0] BSEL_WORD = 4'b1111;

    localparam int unsigned CTRL_DIV_LSB  = 0;
    localparam int unsigned CTRL_DIV_MSB  = 7;
    localparam int unsigned CTRL_SS_BIT   = 8;
    localparam int unsigned CTRL_LOOP_BIT = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_RELEASE
    } state_t;

endpackage

// File: rtl/spi_sd_shifter.sv
// SPI mode-0 byte shifter: SCLK divider, edge sequencing, combined TX/RX shift
// register and a one-cycle done pulse after the eighth falling edge.
module spi_sd_shifter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] txbyte,
    input  logic [7:0] div,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic [7:0] rxbyte,
    output logic       done
);

    logic       busy;
    logic [7:0] div_q;
    logic [7:0] cnt;
    logic [3:0] edge_cnt;
    logic       sclk_q;
    logic       sample_q;
    logic [7:0] sr;
    logic [7:0] rx_q;
    logic       done_q;

    // TX bits leave from sr[7] while RX bits enter at sr[0], so after eight
    // falling edges the register holds the received byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            div_q    <= '0;
            cnt      <= '0;
            edge_cnt <= '0;
            sclk_q   <= 1'b0;
            sample_q <= 1'b0;
            sr       <= '0;
            rx_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start && !busy) begin
                busy     <= 1'b1;
                div_q    <= div;
                cnt      <= '0;
                edge_cnt <= '0;
                sclk_q   <= 1'b0;
                sr       <= txbyte;
            end else if (busy) begin
                if (cnt == div_q) begin
                    cnt      <= '0;
                    edge_cnt <= edge_cnt + 4'd1;
                    if (!sclk_q) begin
                        sclk_q   <= 1'b1;
                        sample_q <= miso;
                    end else begin
                        sclk_q <= 1'b0;
                        sr     <= {sr[6:0], sample_q};
                    end
                    if (edge_cnt == 4'd15) begin
                        busy   <= 1'b0;
                        done_q <= 1'b1;
                        rx_q   <= {sr[6:0], sample_q};
                    end
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end
        end
    end

    assign sclk   = sclk_q;
    assign mosi   = busy ? sr[7] : 1'b1;
    assign rxbyte = rx_q;
    assign done   = done_q;

endmodule

// File: rtl/spi_sd_master.sv
// SD-card SPI master with the DPI-model register map (DATA/STATUS/CTRL).
// Build option: SPI_LOOPBACK_EN adds CTRL[9], routing MOSI back into the shifter.
module spi_sd_master
    import spi_sd_pkg::*;
#(
    parameter logic [7:0] DIV_RESET = 8'd63,
    parameter logic       SS_RESET  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wr_val,
    input  logic [3:0]  bus_bytesel,
    output logic        bus_ack,
    output logic [31:0] bus_data,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_ss_n
);

    state_t      state, state_nxt;
    logic [7:0]  div_q;
    logic        ss_q;
    logic        miso_s1, miso_s2;
    logic [31:0] rd_q;
    logic        start;
    logic        sh_done;
    logic        sh_mosi;
    logic        sh_miso;
    logic [7:0]  rxbyte;
    logic [3:0]  addr;
    logic        data_wr;
    logic        ctrl_wr;
    logic        access;
    logic [31:0] ctrl_val;
    logic [31:0] rd_val;

    assign addr    = bus_addr[3:0];
    assign data_wr = (addr == ADDR_DATA) && (bus_bytesel == BSEL_BYTE);
    assign ctrl_wr = (addr == ADDR_CTRL) && (bus_bytesel == BSEL_WORD);
    assign access  = cs && (state == ST_IDLE);

`ifdef SPI_LOOPBACK_EN
    logic loop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loop_q <= 1'b0;
        end else if (access && ctrl_wr) begin
            loop_q <= bus_wr_val[CTRL_LOOP_BIT];
        end
    end

    assign ctrl_val = {22'b0, loop_q, ss_q, div_q};
    assign sh_miso  = loop_q ? sh_mosi : miso_s2;

    logic unused_bus_bits;
    assign unused_bus_bits = ^{bus_addr[31:4], bus_wr_val[31:10]};
`else
    assign ctrl_val = {22'b0, 1'b0, ss_q, div_q};
    assign sh_miso  = miso_s2;

    logic unused_bus_bits;
    assign unused_bus_bits = ^{bus_addr[31:4], bus_wr_val[31:9]};
`endif

    always_comb begin
        rd_val = '0;
        case (addr)
            ADDR_DATA:   rd_val = data_wr ? '0 : {24'b0, rxbyte};
            ADDR_STATUS: rd_val = {31'b0, state == ST_SHIFT};
            ADDR_CTRL:   rd_val = ctrl_wr ? '0 : ctrl_val;
            default:     rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            div_q   <= DIV_RESET;
            ss_q    <= SS_RESET;
            miso_s1 <= 1'b0;
            miso_s2 <= 1'b0;
            rd_q    <= '0;
        end else begin
            state   <= state_nxt;
            miso_s1 <= spi_miso;
            miso_s2 <= miso_s1;
            if (access) begin
                rd_q <= rd_val;
                if (ctrl_wr) begin
                    div_q <= bus_wr_val[CTRL_DIV_MSB:CTRL_DIV_LSB];
                    ss_q  <= bus_wr_val[CTRL_SS_BIT];
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cs) begin
                    if (data_wr) begin
                        start     = 1'b1;
                        state_nxt = ST_SHIFT;
                    end else begin
                        state_nxt = ST_ACK;
                    end
                end
            end
            ST_SHIFT: begin
                if (sh_done) state_nxt = ST_ACK;
            end
            ST_ACK: state_nxt = ST_WAIT_RELEASE;
            ST_WAIT_RELEASE: begin
                if (!cs) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus_ack  = (state == ST_ACK);
    assign bus_data = (state == ST_ACK) ? rd_q : '0;
    assign spi_ss_n = ss_q;
    assign spi_mosi = sh_mosi;

    spi_sd_shifter u_shifter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .txbyte (bus_wr_val[7:0]),
        .div    (div_q),
        .miso   (sh_miso),
        .sclk   (spi_sclk),
        .mosi   (sh_mosi),
        .rxbyte (rxbyte),
        .done   (sh_done)
    );

endmodule

// File: tb/tb_spi_sd_master.sv
// Directed bench for spi_sd_master with a simple mode-0 card model on MISO.
module tb_spi_sd_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b0;
    logic [31:0] bus_addr = '0;
    logic [31:0] bus_wr_val = '0;
    logic [3:0]  bus_bytesel = '0;
    logic        bus_ack;
    logic [31:0] bus_data;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_ss_n;

    int total = 0;
    int bad = 0;

    int     ack_cnt = 0;
    int     rise_cnt = 0;
    logic [7:0] mosi_bits = '0;
    time    t_last = 0;
    time    t_prev = 0;
    logic [7:0] card_q = 8'hFF;

    spi_sd_master #(.DIV_RESET(8'd63), .SS_RESET(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cs          (cs),
        .bus_addr    (bus_addr),
        .bus_wr_val  (bus_wr_val),
        .bus_bytesel (bus_bytesel),
        .bus_ack     (bus_ack),
        .bus_data    (bus_data),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_ss_n    (spi_ss_n)
    );

    always #5 clk = ~clk;

    // Mode-0 card: MSB presented up front, next bit after each falling SCLK.
    assign spi_miso = card_q[7];
    always @(negedge spi_sclk) card_q <= {card_q[6:0], 1'b1};

    always @(posedge spi_sclk) begin
        rise_cnt  = rise_cnt + 1;
        mosi_bits = {mosi_bits[6:0], spi_mosi};
        t_prev    = t_last;
        t_last    = $time;
    end

    always @(negedge clk) if (bus_ack === 1'b1) ack_cnt = ack_cnt + 1;

    task automatic bus_access(input logic [3:0] a, input logic [31:0] wd, input logic [3:0] bs,
                              output logic [31:0] rd, output int lat);
        cs = 1'b1;
        bus_addr = {28'b0, a};
        bus_wr_val = wd;
        bus_bytesel = bs;
        lat = 0;
        rd = '0;
        while (1) begin
            @(posedge clk); #1;
            lat++;
            if (bus_ack === 1'b1) begin
                rd = bus_data;
                break;
            end
            if (lat >= 3000) begin
                total++; bad++;
                $display("FAIL ack_timeout: addr %h no ack after %0d cycles", a, lat);
                break;
            end
        end
        cs = 1'b0;
        bus_bytesel = '0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int lat;
        total++; if (bus_ack !== 1'b0) begin bad++; $display("FAIL rst_ack: got %b want 0", bus_ack); end
        total++; if (bus_data !== 32'h0) begin bad++; $display("FAIL rst_data: got %h want 0", bus_data); end
        total++; if (spi_sclk !== 1'b0) begin bad++; $display("FAIL rst_sclk: got %b want 0", spi_sclk); end
        total++; if (spi_mosi !== 1'b1) begin bad++; $display("FAIL rst_mosi: got %b want 1", spi_mosi); end
        total++; if (spi_ss_n !== 1'b1) begin bad++; $display("FAIL rst_ss_n: got %b want 1", spi_ss_n); end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        bus_access(4'h8, 32'h0, 4'b0000, rd, lat);
        total++; if (rd !== 32'h0000013F) begin bad++; $display("FAIL rst_ctrl_read: got %h want 0000013f", rd); end
        total++; if (lat !== 1) begin bad++; $display("FAIL rst_ctrl_lat: got %0d want 1", lat); end
    endtask

    task automatic test_div0();
        logic [31:0] rd;
        int lat, r0;
        bus_access(4'h8, 32'h00000100, 4'b1111, rd, lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL div0_ctrl_lat: got %0d want 1", lat); end
        card_q = 8'hA5;
        r0 = rise_cnt;
        bus_access(4'h0, 32'h0000003C, 4'b0001, rd, lat);
        total++; if (lat !== 18) begin bad++; $display("FAIL div0_lat: got %0d want 18", lat); end
        total++; if (rise_cnt - r0 !== 8) begin bad++; $display("FAIL div0_rises: got %0d want 8", rise_cnt - r0); end
        total++; if (mosi_bits !== 8'h3C) begin bad++; $display("FAIL div0_mosi: got %h want 3c", mosi_bits); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL div0_wr_data: got %h want 0", rd); end
        bus_access(4'h4, 32'h0, 4'b0000, rd, lat);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL status_idle: got %h want 0", rd); end
        bus_access(4'hC, 32'h0, 4'b0000, rd, lat);
        total++; if (rd !== 32'h0 || lat !== 1) begin bad++; $display("FAIL unmapped: got %h/%0d want 0/1", rd, lat); end
    endtask

    // Card readback is checked at div=3: below div=2 the MISO synchronizer skews sampling.
    task automatic test_ctrl_div3();
        logic [31:0] rd;
        int lat, r0;
        total++; if (spi_ss_n !== 1'b1) begin bad++; $display("FAIL ss_before: got %b want 1", spi_ss_n); end
        bus_access(4'h8, 32'h00000003, 4'b1111, rd, lat);
        total++; if (spi_ss_n !== 1'b0) begin bad++; $display("FAIL ss_after: got %b want 0", spi_ss_n); end
        card_q = 8'hA5;
        r0 = rise_cnt;
        bus_access(4'h0, 32'h000000FF, 4'b0001, rd, lat);
        total++; if (lat !== 66) begin bad++; $display("FAIL div3_lat: got %0d want 66", lat); end
        total++; if (t_last - t_prev !== 80) begin bad++; $display("FAIL div3_period: got %0t want 80", t_last - t_prev); end
        total++; if (mosi_bits !== 8'hFF || rise_cnt - r0 !== 8) begin bad++; $display("FAIL div3_mosi: got %h/%0d want ff/8", mosi_bits, rise_cnt - r0); end
        bus_access(4'h0, 32'h0, 4'b0000, rd, lat);
        total++; if (rd !== 32'h000000A5) begin bad++; $display("FAIL div3_rx: got %h want 000000a5", rd); end
        bus_access(4'h0, 32'h0, 4'b0011, rd, lat);
        total++; if (rd !== 32'h000000A5) begin bad++; $display("FAIL data_read_bsel3: got %h want 000000a5", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        int lat, r0, a0, n;
        card_q = 8'h81;
        r0 = rise_cnt;
        a0 = ack_cnt;
        cs = 1'b1; bus_addr = 32'h0; bus_wr_val = 32'h3C; bus_bytesel = 4'b0001;
        n = 0;
        while (bus_ack !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) begin total++; bad++; $display("FAIL hold_timeout: got %0d cycles want ack", n); end
        repeat (5) @(posedge clk);
        #1 cs = 1'b0; bus_bytesel = '0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (rise_cnt - r0 !== 8) begin bad++; $display("FAIL hold_rises: got %0d want 8", rise_cnt - r0); end
        total++; if (ack_cnt - a0 !== 1) begin bad++; $display("FAIL hold_acks: got %0d want 1", ack_cnt - a0); end
        bus_access(4'h0, 32'h0, 4'b0000, rd, lat);
        total++; if (rd !== 32'h00000081) begin bad++; $display("FAIL hold_rx: got %h want 00000081", rd); end
    endtask

    task automatic test_loopback();
        logic [31:0] rd;
        int lat;
        bus_access(4'h8, 32'h00000203, 4'b1111, rd, lat);
`ifdef SPI_LOOPBACK_EN
        card_q = 8'h00;
        bus_access(4'h0, 32'h0000005A, 4'b0001, rd, lat);
        bus_access(4'h0, 32'h0, 4'b0000, rd, lat);
        total++; if (rd !== 32'h0000005A) begin bad++; $display("FAIL loop_rx: got %h want 0000005a", rd); end
        bus_access(4'h8, 32'h0, 4'b0000, rd, lat);
        total++; if (rd !== 32'h00000203) begin bad++; $display("FAIL loop_ctrl: got %h want 00000203", rd); end
        bus_access(4'h8, 32'h00000003, 4'b1111, rd, lat);
`else
        bus_access(4'h8, 32'h0, 4'b0000, rd, lat);
        total++; if (rd !== 32'h00000003) begin bad++; $display("FAIL loop_ctrl: got %h want 00000003", rd); end
`endif
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int lat, r0, a0, n;
        bus_access(4'h8, 32'h00000003, 4'b1111, rd, lat);
        card_q = 8'h5A;
        r0 = rise_cnt;
        a0 = ack_cnt;
        cs = 1'b1; bus_addr = 32'h0; bus_wr_val = 32'hC3; bus_bytesel = 4'b0001;
        n = 0;
        while (rise_cnt < r0 + 4 && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) begin total++; bad++; $display("FAIL mid_timeout: got %0d rises want 4", rise_cnt - r0); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (spi_sclk !== 1'b0) begin bad++; $display("FAIL mid_sclk: got %b want 0", spi_sclk); end
        total++; if (spi_ss_n !== 1'b1) begin bad++; $display("FAIL mid_ss_n: got %b want 1", spi_ss_n); end
        total++; if (bus_ack !== 1'b0) begin bad++; $display("FAIL mid_ack: got %b want 0", bus_ack); end
        cs = 1'b0; bus_bytesel = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (ack_cnt - a0 !== 0) begin bad++; $display("FAIL mid_no_ack: got %0d want 0", ack_cnt - a0); end
        bus_access(4'h4, 32'h0, 4'b0000, rd, lat);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL mid_status: got %h want 0", rd); end
        bus_access(4'h0, 32'h0, 4'b0000, rd, lat);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL mid_data: got %h want 0", rd); end
        bus_access(4'h8, 32'h0, 4'b0000, rd, lat);
        total++; if (rd !== 32'h0000013F) begin bad++; $display("FAIL mid_ctrl: got %h want 0000013f", rd); end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_div0();
        test_ctrl_div3();
        test_back_to_back();
        test_loopback();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
